// File: rtl/riscv_mc_ctrl_if.sv
// Interface bundle for the multicycle RISC-V controller.
// master: the controller, which takes IR fields and handshakes and drives datapath controls.
// slave:  the datapath side.
interface riscv_mc_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       memready;
    logic       btaken;
    logic [3:0] alucontrol;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [1:0] immsrc;
    logic       adrsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, memready, btaken,
        output alucontrol, alusrca, alusrcb, resultsrc, immsrc,
               adrsrc, irwrite, pcwrite, regwrite, memwrite, state, illegal
    );

    modport slave (
        output op, funct3, funct7b5, memready, btaken,
        input  alucontrol, alusrca, alusrcb, resultsrc, immsrc,
               adrsrc, irwrite, pcwrite, regwrite, memwrite, state, illegal
    );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// Multicycle RISC-V (RV32I subset: lw, sw, R/I ALU, beq, jal) Moore control FSM.
// Optional macro RISCV_MC_CTRL_TRAP_EN: an illegal decode enters a sticky TRAP
// state and raises illegal. Without it, an illegal decode is a NOP back to FETCH.
module riscv_mc_ctrl (
    input  logic            clk,
    input  logic            reset,
    riscv_mc_ctrl_if.master bus
);

`ifdef RISCV_MC_CTRL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    typedef struct packed {
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic [3:0] alucontrol;
        logic       adrsrc;
        logic       regwrite;
        logic       memwrite;
        logic       pcwrite;
    } ctl_t;

    localparam ctl_t CTL_FETCH = '{alusrca: 2'b00, alusrcb: 2'b10, resultsrc: 2'b10,
                                   alucontrol: 4'b0000, adrsrc: 1'b0, regwrite: 1'b0,
                                   memwrite: 1'b0, pcwrite: 1'b0};

    state_t state_q;
    state_t state_d;
    ctl_t   ctl_q;
    ctl_t   ctl_d;
    logic   illegal_q;
    logic   alu_f3_ok;
    logic   legal;
    logic   in_fetch;
    logic   in_beq;

    // Registered control word for a state; memready/btaken-qualified strobes are added outside
    function automatic ctl_t ctl_for(input state_t s, input logic [2:0] f3, input logic f7b5);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:    c = CTL_FETCH;
            DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
            MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
            MEMREAD:  c.adrsrc = 1'b1;
            MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
            MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
            EXECR:    begin c.alusrca = 2'b10; c.alucontrol = {f7b5, f3}; end
            EXECI:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.alucontrol = {1'b0, f3}; end
            ALUWB:    c.regwrite = 1'b1;
            JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcwrite = 1'b1; end
            BEQ:      c.alusrca = 2'b10;
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Legality check of the instruction held in the IR
    always_comb begin
        alu_f3_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b010) ||
                    (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
        case (bus.op)
            OP_LOAD, OP_STORE: legal = (bus.funct3 == 3'b010);
            OP_RTYPE:          legal = alu_f3_ok && (!bus.funct7b5 || (bus.funct3 == 3'b000));
            OP_ITYPE:          legal = alu_f3_ok;
            OP_BRANCH:         legal = (bus.funct3 == 3'b000);
            OP_JAL:            legal = 1'b1;
            default:           legal = 1'b0;
        endcase
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (bus.memready) state_d = DECODE;
            DECODE: begin
                if (!legal) begin
                    state_d = TRAP_EN ? TRAP : FETCH;
                end else begin
                    case (bus.op)
                        OP_LOAD, OP_STORE: state_d = MEMADR;
                        OP_RTYPE:          state_d = EXECR;
                        OP_ITYPE:          state_d = EXECI;
                        OP_JAL:            state_d = JAL;
                        OP_BRANCH:         state_d = BEQ;
                        default:           state_d = FETCH;
                    endcase
                end
            end
            MEMADR:   state_d = bus.op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (bus.memready) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (bus.memready) state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            JAL:      state_d = ALUWB;
            BEQ:      state_d = FETCH;
            TRAP:     state_d = TRAP_EN ? TRAP : FETCH;
            default:  state_d = FETCH;
        endcase
        ctl_d = ctl_for(state_d, bus.funct3, bus.funct7b5);
    end

    // State, registered control word and sticky illegal flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            ctl_q     <= CTL_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctl_q     <= ctl_d;
            illegal_q <= illegal_q | (TRAP_EN & (state_d == TRAP));
        end
    end

    // FETCH and BEQ strobes follow memready/btaken in the same cycle, so they are
    // qualified by the registered state and held off directly by reset.
    assign in_fetch = (state_q == FETCH);
    assign in_beq   = (state_q == BEQ);

    assign bus.irwrite    = !reset && in_fetch && bus.memready;
    assign bus.pcwrite    = !reset && (ctl_q.pcwrite || (in_fetch && bus.memready) ||
                                       (in_beq && bus.btaken));
    assign bus.regwrite   = ctl_q.regwrite;
    assign bus.memwrite   = ctl_q.memwrite;
    assign bus.adrsrc     = ctl_q.adrsrc;
    assign bus.alusrca    = ctl_q.alusrca;
    assign bus.alusrcb    = ctl_q.alusrcb;
    assign bus.resultsrc  = ctl_q.resultsrc;
    assign bus.alucontrol = ctl_q.alucontrol;
    assign bus.state      = state_q;
    assign bus.illegal    = illegal_q;

    // Immediate format straight from the opcode
    always_comb begin
        case (bus.op)
            OP_STORE:  bus.immsrc = 2'b01;
            OP_BRANCH: bus.immsrc = 2'b10;
            OP_JAL:    bus.immsrc = 2'b11;
            default:   bus.immsrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed self-checking bench for riscv_mc_ctrl (default or RISCV_MC_CTRL_TRAP_EN build).
module tb_riscv_mc_ctrl;

`ifdef RISCV_MC_CTRL_TRAP_EN
    localparam logic [3:0] ILL_STATE = 4'd11;
    localparam logic       ILL_FLAG  = 1'b1;
    localparam logic       ILL_PCW   = 1'b0;
`else
    localparam logic [3:0] ILL_STATE = 4'd0;
    localparam logic       ILL_FLAG  = 1'b0;
    localparam logic       ILL_PCW   = 1'b1;
`endif

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    riscv_mc_ctrl_if bus ();

    riscv_mc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        bus.op       = o;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
    endtask

    logic [6:0] ill_op [5];
    logic [2:0] ill_f3 [5];
    logic       ill_f7 [5];

    initial begin
        tests = 0;
        fails = 0;
        ill_op = '{7'b1100011, 7'b0110011, 7'b0010011, 7'b0000011, 7'b0000000};
        ill_f3 = '{3'b001,     3'b010,     3'b001,     3'b000,     3'b000};
        ill_f7 = '{1'b0,       1'b1,       1'b0,       1'b0,       1'b0};

        reset        = 1'b1;
        bus.memready = 1'b1;
        bus.btaken   = 1'b0;
        set_instr(7'b0000000, 3'b000, 1'b0);

        // Reset state, strobes forced low even with memready high
        #3;
        check("rst_state",     bus.state, 4'd0);
        check("rst_irwrite",   bus.irwrite, 1'b0);
        check("rst_pcwrite",   bus.pcwrite, 1'b0);
        check("rst_regwrite",  bus.regwrite, 1'b0);
        check("rst_memwrite",  bus.memwrite, 1'b0);
        check("rst_illegal",   bus.illegal, 1'b0);
        check("rst_alusrcb",   bus.alusrcb, 2'b10);
        check("rst_resultsrc", bus.resultsrc, 2'b10);
        cyc();
        cyc();
        reset        = 1'b0;
        bus.memready = 1'b0;
        #1;
        check("fetch_wait_irwrite", bus.irwrite, 1'b0);

        // FETCH holds while memready is low
        cyc();
        check("fetch_hold_state", bus.state, 4'd0);

        // R-type sub
        set_instr(7'b0110011, 3'b000, 1'b1);
        bus.memready = 1'b1;
        #1;
        check("fetch_irwrite", bus.irwrite, 1'b1);
        check("fetch_pcwrite", bus.pcwrite, 1'b1);
        check("r_immsrc", bus.immsrc, 2'b00);
        cyc();
        check("r_decode_state", bus.state, 4'd1);
        check("decode_alusrca", bus.alusrca, 2'b01);
        check("decode_alusrcb", bus.alusrcb, 2'b01);
        check("decode_irwrite", bus.irwrite, 1'b0);
        check("decode_pcwrite", bus.pcwrite, 1'b0);
        cyc();
        check("r_execr_state", bus.state, 4'd6);
        check("r_execr_alu", bus.alucontrol, 4'b1000);
        check("r_execr_alusrca", bus.alusrca, 2'b10);
        check("r_execr_alusrcb", bus.alusrcb, 2'b00);
        check("r_execr_regwrite", bus.regwrite, 1'b0);
        cyc();
        check("r_aluwb_state", bus.state, 4'd7);
        check("r_aluwb_regwrite", bus.regwrite, 1'b1);
        check("r_aluwb_resultsrc", bus.resultsrc, 2'b00);
        cyc();
        check("r_done_state", bus.state, 4'd0);
        check("r_done_regwrite", bus.regwrite, 1'b0);

        // addi with funct7b5 set
        set_instr(7'b0010011, 3'b000, 1'b1);
        cyc();
        check("i_decode_state", bus.state, 4'd1);
        cyc();
        check("i_execi_state", bus.state, 4'd8);
        check("i_execi_alu", bus.alucontrol, 4'b0000);
        check("i_execi_alusrcb", bus.alusrcb, 2'b01);
        cyc();
        check("i_aluwb_state", bus.state, 4'd7);
        cyc();
        check("i_done_state", bus.state, 4'd0);

        // lw with two memready-low cycles in MEMREAD
        set_instr(7'b0000011, 3'b010, 1'b0);
        #1;
        check("lw_immsrc", bus.immsrc, 2'b00);
        cyc();
        check("lw_decode_state", bus.state, 4'd1);
        cyc();
        check("lw_memadr_state", bus.state, 4'd2);
        check("lw_memadr_alusrca", bus.alusrca, 2'b10);
        check("lw_memadr_alusrcb", bus.alusrcb, 2'b01);
        bus.memready = 1'b0;
        cyc();
        check("lw_memread1_state", bus.state, 4'd3);
        check("lw_memread_adrsrc", bus.adrsrc, 1'b1);
        check("lw_memread_regwrite", bus.regwrite, 1'b0);
        cyc();
        check("lw_memread2_state", bus.state, 4'd3);
        cyc();
        check("lw_memread3_state", bus.state, 4'd3);
        bus.memready = 1'b1;
        cyc();
        check("lw_memwb_state", bus.state, 4'd4);
        check("lw_memwb_regwrite", bus.regwrite, 1'b1);
        check("lw_memwb_resultsrc", bus.resultsrc, 2'b01);
        cyc();
        check("lw_done_state", bus.state, 4'd0);

        // beq, btaken both ways in the same BEQ cycle
        set_instr(7'b1100011, 3'b000, 1'b0);
        #1;
        check("beq_immsrc", bus.immsrc, 2'b10);
        cyc();
        check("beq_decode_state", bus.state, 4'd1);
        cyc();
        check("beq_state", bus.state, 4'd10);
        check("beq_alusrca", bus.alusrca, 2'b10);
        bus.btaken = 1'b1;
        #1;
        check("beq_taken_pcwrite", bus.pcwrite, 1'b1);
        bus.btaken = 1'b0;
        #1;
        check("beq_nottaken_pcwrite", bus.pcwrite, 1'b0);
        cyc();
        check("beq_done_state", bus.state, 4'd0);

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        #1;
        check("jal_immsrc", bus.immsrc, 2'b11);
        cyc();
        cyc();
        check("jal_state", bus.state, 4'd9);
        check("jal_pcwrite", bus.pcwrite, 1'b1);
        check("jal_alusrca", bus.alusrca, 2'b01);
        check("jal_alusrcb", bus.alusrcb, 2'b10);
        cyc();
        check("jal_aluwb_state", bus.state, 4'd7);
        check("jal_aluwb_pcwrite", bus.pcwrite, 1'b0);
        cyc();
        check("jal_done_state", bus.state, 4'd0);

        // sw aborted by reset mid-MEMWRITE
        set_instr(7'b0100011, 3'b010, 1'b0);
        #1;
        check("sw_immsrc", bus.immsrc, 2'b01);
        cyc();
        cyc();
        check("sw_memadr_state", bus.state, 4'd2);
        bus.memready = 1'b0;
        cyc();
        check("sw_memwrite_state", bus.state, 4'd5);
        check("sw_memwrite", bus.memwrite, 1'b1);
        check("sw_adrsrc", bus.adrsrc, 1'b1);
        cyc();
        check("sw_memwrite_held", bus.memwrite, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("sw_rst_memwrite", bus.memwrite, 1'b0);
        check("sw_rst_state", bus.state, 4'd0);
        cyc();
        reset        = 1'b0;
        bus.memready = 1'b1;
        #1;
        check("sw_after_rst_state", bus.state, 4'd0);

        // Illegal decodes
        for (int i = 0; i < 5; i++) begin
            set_instr(ill_op[i], ill_f3[i], ill_f7[i]);
            cyc();
            check("ill_decode_state", bus.state, 4'd1);
            cyc();
            check("ill_state", bus.state, ILL_STATE);
            check("ill_flag", bus.illegal, ILL_FLAG);
            check("ill_pcwrite", bus.pcwrite, ILL_PCW);
            check("ill_regwrite", bus.regwrite, 1'b0);
`ifdef RISCV_MC_CTRL_TRAP_EN
            if (i == 4) begin
                for (int k = 0; k < 10; k++) begin
                    cyc();
                    check("trap_hold_state", bus.state, 4'd11);
                    check("trap_hold_flag", bus.illegal, 1'b1);
                    check("trap_hold_memwrite", bus.memwrite, 1'b0);
                end
            end
            reset = 1'b1;
            #1;
            reset = 1'b0;
            #1;
            check("trap_rst_flag", bus.illegal, 1'b0);
            check("trap_rst_state", bus.state, 4'd0);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
